// File: rtl/fighter_state_fsm_pkg.sv
// rtl/fighter_state_fsm_pkg.sv - shared fighter state codes and phase counter width
package fighter_state_fsm_pkg;

  localparam int PHASE_W = 6;

  // Codes are consumed directly by the sprite renderer; keep values stable.
  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_BWD        = 4'd1,
    S_FWD        = 4'd2,
    S_ATK_START  = 4'd3,
    S_ATK_ACTIVE = 4'd4,
    S_ATK_RECOV  = 4'd5,
    S_DIR_START  = 4'd6,
    S_DIR_ACTIVE = 4'd7,
    S_DIR_RECOV  = 4'd8,
    S_HITSTUN    = 4'd9,
    S_BLOCKSTUN  = 4'd10
  } state_e;

  function automatic logic is_timed(input state_e s);
    return s inside {[S_ATK_START:S_BLOCKSTUN]};
  endfunction

endpackage

// File: rtl/fighter_state_fsm_phase_timer.sv
// rtl/fighter_state_fsm_phase_timer.sv - per-frame countdown for timed fighter phases
module fighter_state_fsm_phase_timer
  import fighter_state_fsm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tick,
  input  logic               i_load,
  input  logic [PHASE_W-1:0] i_value,
  output logic [PHASE_W-1:0] o_value,
  output logic               o_last
);

  logic [PHASE_W-1:0] r_value;

  // Saturates at zero so neutral states sit at 0 without an explicit load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
    end else if (i_tick) begin
      if (i_load) begin
        r_value <= i_value;
      end else if (r_value != '0) begin
        r_value <= r_value - 1'b1;
      end
    end
  end

  assign o_value = r_value;
  assign o_last  = (r_value == PHASE_W'(1));

endmodule

// File: rtl/fighter_state_fsm.sv
// rtl/fighter_state_fsm.sv - per-player fighter state machine driving the sprite state code
module fighter_state_fsm
  import fighter_state_fsm_pkg::*;
#(
  parameter bit IS_MIRRORED = 1'b0,
  parameter int ATK_START   = 4,
  parameter int ATK_ACTIVE  = 2,
  parameter int ATK_RECOV   = 6,
  parameter int DIR_START   = 6,
  parameter int DIR_ACTIVE  = 3,
  parameter int DIR_RECOV   = 8,
  parameter int HITSTUN     = 12,
  parameter int BLOCKSTUN   = 8
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_attack,
  input  logic               hit_in,
  output logic [3:0]         state,
  output logic               hitbox_active,
  output logic               blocking,
  output logic [PHASE_W-1:0] phase_left
);

  generate
    if (ATK_START < 1 || ATK_START > 63 || ATK_ACTIVE < 1 || ATK_ACTIVE > 63 ||
        ATK_RECOV < 1 || ATK_RECOV > 63 || DIR_START < 1 || DIR_START > 63 ||
        DIR_ACTIVE < 1 || DIR_ACTIVE > 63 || DIR_RECOV < 1 || DIR_RECOV > 63 ||
        HITSTUN < 1 || HITSTUN > 63 || BLOCKSTUN < 1 || BLOCKSTUN > 63) begin : g_bad_param
      $error("fighter_state_fsm: frame parameters must be in 1..63");
    end
  endgenerate

  state_e             r_state;
  state_e             w_next;
  logic               r_hit_pend;
  logic               r_atk_prev;
  logic               r_hitbox;
  logic               r_blocking;
  logic               w_hit;
  logic               w_fwd;
  logic               w_back;
  logic               w_only_fwd;
  logic               w_only_back;
  logic               w_atk_edge;
  logic               w_load;
  logic               w_last;
  logic [PHASE_W-1:0] w_load_val;
  logic [PHASE_W-1:0] w_phase;

  function automatic logic [PHASE_W-1:0] phase_len(input state_e s);
    case (s)
      S_ATK_START:  return PHASE_W'(ATK_START);
      S_ATK_ACTIVE: return PHASE_W'(ATK_ACTIVE);
      S_ATK_RECOV:  return PHASE_W'(ATK_RECOV);
      S_DIR_START:  return PHASE_W'(DIR_START);
      S_DIR_ACTIVE: return PHASE_W'(DIR_ACTIVE);
      S_DIR_RECOV:  return PHASE_W'(DIR_RECOV);
      S_HITSTUN:    return PHASE_W'(HITSTUN);
      S_BLOCKSTUN:  return PHASE_W'(BLOCKSTUN);
      default:      return '0;
    endcase
  endfunction

  assign w_hit       = r_hit_pend | hit_in;
  assign w_fwd       = IS_MIRRORED ? btn_left : btn_right;
  assign w_back      = IS_MIRRORED ? btn_right : btn_left;
  assign w_only_fwd  = w_fwd & ~w_back;
  assign w_only_back = w_back & ~w_fwd;
  assign w_atk_edge  = btn_attack & ~r_atk_prev;

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    if (w_hit) begin
      if (r_state == S_IDLE || r_state == S_BWD || (r_state == S_BLOCKSTUN && w_only_back)) begin
        w_next = S_BLOCKSTUN;
      end else begin
        w_next = S_HITSTUN;
      end
      w_load = 1'b1;
    end else if (is_timed(r_state)) begin
      if (w_last) begin
        case (r_state)
          S_ATK_START:  w_next = S_ATK_ACTIVE;
          S_ATK_ACTIVE: w_next = S_ATK_RECOV;
          S_DIR_START:  w_next = S_DIR_ACTIVE;
          S_DIR_ACTIVE: w_next = S_DIR_RECOV;
          default:      w_next = S_IDLE;
        endcase
        w_load = 1'b1;
      end
    end else if (w_atk_edge) begin
      w_next = w_only_fwd ? S_DIR_START : S_ATK_START;
      w_load = 1'b1;
    end else if (w_only_fwd) begin
      w_next = S_FWD;
    end else if (w_only_back) begin
      w_next = S_BWD;
    end else begin
      w_next = S_IDLE;
    end
    w_load_val = phase_len(w_next);
  end

  // atk_prev resets high so an attack button held through reset needs a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_hit_pend <= 1'b0;
      r_atk_prev <= 1'b1;
      r_hitbox   <= 1'b0;
      r_blocking <= 1'b0;
    end else if (frame_tick) begin
      r_state    <= w_next;
      r_atk_prev <= btn_attack;
      r_hitbox   <= (w_next == S_ATK_ACTIVE) || (w_next == S_DIR_ACTIVE);
      r_blocking <= (w_next == S_BLOCKSTUN);
      r_hit_pend <= 1'b0;
    end else if (hit_in) begin
      r_hit_pend <= 1'b1;
    end
  end

  fighter_state_fsm_phase_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_tick  (frame_tick),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_value (w_phase),
    .o_last  (w_last)
  );

  assign state         = r_state;
  assign hitbox_active = r_hitbox;
  assign blocking      = r_blocking;
  assign phase_left    = w_phase;

endmodule

// File: tb/tb_fighter_state_fsm.sv
// tb/tb_fighter_state_fsm.sv - bench for two fighter instances (normal and mirrored)
module tb_fighter_state_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_tick = 1'b0;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic btn_attack = 1'b0;
  logic hit_in = 1'b0;

  logic [3:0] st0, st1;
  logic       hb0, hb1, bl0, bl1;
  logic [5:0] pl0, pl1;

  int  n_checks = 0;
  int  n_fail = 0;
  bit  chk_en = 1'b0;

  int  m_state[2];
  int  m_left[2];
  bit  m_pend[2];
  bit  m_prev[2];

  always #5 clk = ~clk;

  fighter_state_fsm #(.IS_MIRRORED(1'b0)) u0 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_left(btn_left),
    .btn_right(btn_right), .btn_attack(btn_attack), .hit_in(hit_in),
    .state(st0), .hitbox_active(hb0), .blocking(bl0), .phase_left(pl0)
  );

  fighter_state_fsm #(.IS_MIRRORED(1'b1)) u1 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_left(btn_left),
    .btn_right(btn_right), .btn_attack(btn_attack), .hit_in(hit_in),
    .state(st1), .hitbox_active(hb1), .blocking(bl1), .phase_left(pl1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int plen(input int s);
    case (s)
      3: return 4;   4: return 2;  5: return 6;
      6: return 6;   7: return 3;  8: return 8;
      9: return 12; 10: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic int chain_after(input int s);
    case (s)
      3: return 4; 4: return 5;
      6: return 7; 7: return 8;
      default: return 0;
    endcase
  endfunction

  task automatic model_tick(input int k);
    int s;
    bit hit, f, b, only_f, only_b, edge_seen;
    s         = m_state[k];
    hit       = m_pend[k] | hit_in;
    f         = (k == 1) ? btn_left : btn_right;
    b         = (k == 1) ? btn_right : btn_left;
    only_f    = f && !b;
    only_b    = b && !f;
    edge_seen = btn_attack && !m_prev[k];
    if (hit) begin
      s = (s <= 1 || (s == 10 && only_b)) ? 10 : 9;
      m_left[k] = plen(s);
    end else if (s >= 3) begin
      if (m_left[k] > 1) begin
        m_left[k] = m_left[k] - 1;
      end else begin
        s = chain_after(s);
        m_left[k] = plen(s);
      end
    end else if (edge_seen) begin
      s = only_f ? 6 : 3;
      m_left[k] = plen(s);
    end else begin
      s = only_f ? 2 : (only_b ? 1 : 0);
    end
    m_state[k] = s;
    m_prev[k]  = btn_attack;
    m_pend[k]  = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_state[k] = 0;
        m_left[k]  = 0;
        m_pend[k]  = 1'b0;
        m_prev[k]  = 1'b1;
      end else if (frame_tick) begin
        model_tick(k);
      end else if (hit_in) begin
        m_pend[k] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("u0.state", int'(st0), m_state[0]);
      chk("u0.phase_left", int'(pl0), m_left[0]);
      chk("u0.hitbox", int'(hb0), int'(m_state[0] == 4 || m_state[0] == 7));
      chk("u0.blocking", int'(bl0), int'(m_state[0] == 10));
      chk("u1.state", int'(st1), m_state[1]);
      chk("u1.phase_left", int'(pl1), m_left[1]);
      chk("u1.hitbox", int'(hb1), int'(m_state[1] == 4 || m_state[1] == 7));
      chk("u1.blocking", int'(bl1), int'(m_state[1] == 10));
    end
  end

  task automatic do_tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic pulse_hit();
    @(negedge clk);
    hit_in = 1'b1;
    @(negedge clk);
    hit_in = 1'b0;
  endtask

  initial begin
    int hb_count;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset state", int'(st0), 0);
    chk("reset phase", int'(pl0), 0);
    chk("reset hitbox", int'(hb0), 0);

    // Walking: forward for u0 is back for the mirrored u1
    btn_right = 1'b1;
    do_tick();
    chk("walk fwd u0", int'(st0), 2);
    chk("walk back u1", int'(st1), 1);
    ticks(2);
    btn_right = 1'b0;
    do_tick();
    chk("walk release", int'(st0), 0);

    // Neutral attack chain 4/2/6
    btn_attack = 1'b1;
    do_tick();
    chk("atk start", int'(st0), 3);
    chk("atk start len", int'(pl0), 4);
    hb_count = 0;
    for (int i = 0; i < 12; i++) begin
      do_tick();
      if (hb0) hb_count++;
    end
    chk("atk hitbox ticks", hb_count, 2);
    chk("atk end", int'(st0), 0);
    do_tick();
    chk("held atk no retrigger", int'(st0), 0);
    btn_attack = 1'b0;
    do_tick();

    // Mirrored directional attack 6/3/8
    btn_left = 1'b1;
    do_tick();
    chk("mirror fwd", int'(st1), 2);
    btn_attack = 1'b1;
    do_tick();
    chk("dir start", int'(st1), 6);
    chk("dir start len", int'(pl1), 6);
    hb_count = 0;
    for (int i = 0; i < 17; i++) begin
      do_tick();
      if (hb1) hb_count++;
    end
    chk("dir hitbox ticks", hb_count, 3);
    chk("dir end", int'(st1), 0);
    btn_attack = 1'b0;
    btn_left = 1'b0;
    do_tick();

    // Counter-hit during AtkA, then re-hit restarting hitstun
    btn_attack = 1'b1;
    do_tick();
    ticks(4);
    chk("reach atk active", int'(st0), 4);
    pulse_hit();
    do_tick();
    chk("counter hit", int'(st0), 9);
    chk("hitstun len", int'(pl0), 12);
    ticks(9);
    chk("hitstun at 3", int'(pl0), 3);
    pulse_hit();
    do_tick();
    chk("rehit restarts", int'(pl0), 12);
    ticks(12);
    chk("hitstun end", int'(st0), 0);
    btn_attack = 1'b0;
    do_tick();

    // Block while walking back; mirrored instance walks forward and is hit
    btn_left = 1'b1;
    do_tick();
    @(negedge clk);
    frame_tick = 1'b1;
    hit_in = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    hit_in = 1'b0;
    chk("block state", int'(st0), 10);
    chk("blocking flag", int'(bl0), 1);
    chk("fwd gets hit", int'(st1), 9);
    ticks(7);
    chk("still blocking", int'(bl0), 1);
    do_tick();
    chk("blockstun end", int'(st0), 0);
    btn_left = 1'b0;
    do_tick();

    // Async reset mid-DirS; held attack must be re-pressed
    btn_right = 1'b1;
    btn_attack = 1'b1;
    do_tick();
    chk("dirs before reset", int'(st0), 6);
    ticks(2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async reset state", int'(st0), 0);
    chk("async reset phase", int'(pl0), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    do_tick();
    chk("held atk after reset", int'(st0), 2);
    btn_attack = 1'b0;
    do_tick();
    btn_attack = 1'b1;
    do_tick();
    chk("repress after reset", int'(st0), 6);

    // Random soak against the model
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) btn_left = ~btn_left;
      if ($urandom_range(0, 7) == 0) btn_right = ~btn_right;
      if ($urandom_range(0, 5) == 0) btn_attack = ~btn_attack;
      hit_in = ($urandom_range(0, 29) == 0);
      if (rst) begin
        #2 rst = 1'b0;
      end else if ($urandom_range(0, 1499) == 0) begin
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    frame_tick = 1'b0;
    hit_in = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
